arb_rr_n: RTL

- Parametrised N-input packet arbiter; successor to the fixed 3-input arbiter.
- Merges N valid/data sink streams into one source stream.
- Adds ready/valid backpressure on both sides, round-robin or fixed priority, and multi-beat packet locking.
- One registered output stage; sits between producer units and a shared bus/FIFO.

---
 rtl/arb_rr_n_pkg.sv | 9 +
 rtl/arb_rr_pick.sv | 40 ++++
 rtl/arb_rr_n.sv | 95 +++++++++
 3 files changed

// File: rtl/arb_rr_n_pkg.sv
// Shared constants for the N-input packet arbiter and its picker.
// Mode encodings select rotating versus lowest-index priority.
package arb_rr_n_pkg;

    localparam logic ARB_MODE_RR    = 1'b0;
    localparam logic ARB_MODE_FIXED = 1'b1;
    localparam int   ARB_DEF_W      = 32;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational rotate-priority picker: one-hot grant plus encoded index, zero when no request.
// Round-robin scans ptr, ptr+1, ... modulo N; fixed mode scans from index 0.
module arb_rr_pick
    import arb_rr_n_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] idx
);

    localparam logic [CW:0] NUM = (CW+1)'(N);

    logic [CW:0] pos;
    logic        found;

    // One spare bit on pos so ptr+k cannot overflow before the modulo-N fold.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = (mode == ARB_MODE_FIXED) ? (CW+1)'(k) : ({1'b0, ptr} + (CW+1)'(k));
            if (pos >= NUM) begin
                pos = pos - NUM;
            end
            if (!found && req[pos[CW-1:0]]) begin
                found                = 1'b1;
                gnt[pos[CW-1:0]]     = 1'b1;
                idx                  = pos[CW-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_rr_n.sv
// N-input packet arbiter with multi-beat locking into one registered output stage.
// Accepted beat appears 1 cycle later; sinks see ready only when the output register can load.
module arb_rr_n
    import arb_rr_n_pkg::*;
#(
    parameter int N    = 3,
    parameter int W    = ARB_DEF_W,
    parameter int MODE = 0,
    parameter int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] iSnkData,
    input  logic [N-1:0]   iSnkValid,
    input  logic [N-1:0]   iSnkLast,
    output logic [N-1:0]   oSnkReady,
    output logic [W-1:0]   oSrcData,
    output logic           oSrcValid,
    output logic           oSrcLast,
    output logic [CW-1:0]  oSrcChan,
    input  logic           iSrcReady
);

    localparam logic MODE_L = (MODE == 1) ? ARB_MODE_FIXED : ARB_MODE_RR;

    logic [CW-1:0] ptr;
    logic          lock;
    logic [CW-1:0] lock_ch;

    logic          load;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [CW-1:0] idx;
    logic          xfer;
    logic [W-1:0]  sel_dat;
    logic          sel_last;

    assign load = !oSrcValid | iSrcReady;

    // While locked, only the owning channel may compete, even if it is idle.
    assign req = lock ? (iSnkValid & (N'(1) << lock_ch)) : iSnkValid;

    arb_rr_pick #(
        .N  (N),
        .CW (CW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .mode (MODE_L),
        .gnt  (gnt),
        .idx  (idx)
    );

    assign oSnkReady = gnt & {N{load & rst}};
    assign xfer      = |oSnkReady;
    assign sel_last  = |(gnt & iSnkLast);

    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_dat = sel_dat | iSnkData[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oSrcValid <= 1'b0;
            oSrcData  <= '0;
            oSrcLast  <= 1'b0;
            oSrcChan  <= '0;
            ptr       <= '0;
            lock      <= 1'b0;
            lock_ch   <= '0;
        end else if (load) begin
            oSrcValid <= xfer;
            if (xfer) begin
                oSrcData <= sel_dat;
                oSrcLast <= sel_last;
                oSrcChan <= idx;
                if (!sel_last) begin
                    lock    <= 1'b1;
                    lock_ch <= idx;
                end else begin
                    lock <= 1'b0;
                    if (MODE_L == ARB_MODE_RR) begin
                        ptr <= (idx == CW'(N-1)) ? '0 : idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule
